pc_unit: RTL and testbench

//  Parametrised program-counter unit for the multicycle MIPS core. Holds the fetch address and advances it by 4 on

---
 rtl/pc_unit.sv | 178 +++++++++++++++++
 tb/tb_pc_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the multicycle MIPS core.
//
// Holds the fetch address and steps it by 4 on every advance strobe. Branch and
// jump codes from decode are evaluated against the ALU flags. A taken target is
// applied after one architectural delay slot. The unit also provides a link
// address, misaligned-target detection, branch-in-delay-slot detection and a
// sticky halt.
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   advance                step to the next instruction this cycle
//   resolve                branch fields valid; the branch is at `address`
//   internal_code          decoded opcode (30..41 are control instructions)
//   offset, instr_index    branch offset / jump index, both in words
//   register_data          rs value used by JR/JALR
//   zero/positive/negative ALU compare flags
//   address                current fetch address
//   delay_slot             instruction at `address` is a delay slot
//   link_address, link_we  return address (address+8) and its write enable
//   addr_err               1-cycle pulse: taken target not word aligned
//   ds_branch_err          1-cycle pulse: control op resolved inside a branch shadow
//   halt                   address reached HALT_ADDR, or core is halted
module pc_unit #(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = '0,
  parameter int                OFFSET_W     = 16,
  parameter int                INDEX_W      = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic                resolve,
  input  logic [6:0]          internal_code,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [INDEX_W-1:0]  instr_index,
  input  logic [ADDR_W-1:0]   register_data,
  input  logic                zero,
  input  logic                positive,
  input  logic                negative,
  output logic [ADDR_W-1:0]   address,
  output logic                delay_slot,
  output logic [ADDR_W-1:0]   link_address,
  output logic                link_we,
  output logic                addr_err,
  output logic                ds_branch_err,
  output logic                halt
);

  localparam logic [6:0] CODE_BEQ    = 7'd30;
  localparam logic [6:0] CODE_BGEZ   = 7'd31;
  localparam logic [6:0] CODE_BGEZAL = 7'd32;
  localparam logic [6:0] CODE_BGTZ   = 7'd33;
  localparam logic [6:0] CODE_BLEZ   = 7'd34;
  localparam logic [6:0] CODE_BLTZ   = 7'd35;
  localparam logic [6:0] CODE_BLTZAL = 7'd36;
  localparam logic [6:0] CODE_BNE    = 7'd37;
  localparam logic [6:0] CODE_J      = 7'd38;
  localparam logic [6:0] CODE_JAL    = 7'd39;
  localparam logic [6:0] CODE_JALR   = 7'd40;
  localparam logic [6:0] CODE_JR     = 7'd41;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  // RUN: no pending branch. TAKEN: target latched, the branch is still at
  // address. DELAY: the delay slot is at address. HALTED: exits only on reset.
  typedef enum logic [1:0] {S_RUN, S_TAKEN, S_DELAY, S_HALTED} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   address_reg, address_next;
  logic [ADDR_W-1:0]   target_reg, target_next;
  logic                addr_err_reg, addr_err_next;
  logic                ds_err_reg, ds_err_next;

  logic [ADDR_W-1:0]   seq_addr;
  logic [ADDR_W-1:0]   sext_offset;
  logic [ADDR_W-1:0]   branch_target;
  logic [ADDR_W-1:0]   jump_target;
  logic [ADDR_W-1:0]   target;
  logic                is_control;
  logic                is_link;
  logic                taken;

  // Branch fields always refer to the pre-advance address (bpc).
  assign seq_addr      = address_reg + STEP;
  assign sext_offset   = {{(ADDR_W-OFFSET_W){offset[OFFSET_W-1]}}, offset};
  assign branch_target = seq_addr + (sext_offset << 2);
  assign jump_target   = {seq_addr[ADDR_W-1:INDEX_W+2], instr_index, 2'b00};

  always_comb begin
    is_control = 1'b1;
    is_link    = 1'b0;
    taken      = 1'b0;
    target     = branch_target;
    case (internal_code)
      CODE_BEQ:    taken = zero;
      CODE_BNE:    taken = !zero;
      CODE_BGTZ:   taken = positive;
      CODE_BLEZ:   taken = zero | negative;
      CODE_BGEZ:   taken = positive | zero;
      CODE_BGEZAL: begin taken = positive | zero; is_link = 1'b1; end
      CODE_BLTZ:   taken = negative;
      CODE_BLTZAL: begin taken = negative; is_link = 1'b1; end
      CODE_J:      begin taken = 1'b1; target = jump_target; end
      CODE_JAL:    begin taken = 1'b1; target = jump_target; is_link = 1'b1; end
      CODE_JR:     begin taken = 1'b1; target = register_data; end
      CODE_JALR:   begin taken = 1'b1; target = register_data; is_link = 1'b1; end
      default:     is_control = 1'b0;
    endcase
  end

  assign halt         = (address_reg == HALT_ADDR) || (state_reg == S_HALTED);
  assign address      = address_reg;
  assign delay_slot   = (state_reg == S_DELAY);
  assign link_address = address_reg + ADDR_W'(8);
  assign link_we      = resolve && is_link && !halt;
  assign addr_err     = addr_err_reg;
  assign ds_branch_err = ds_err_reg;

  always_comb begin
    state_next    = state_reg;
    address_next  = address_reg;
    target_next   = target_reg;
    addr_err_next = 1'b0;
    ds_err_next   = 1'b0;
    if (halt) begin
      // Halt overrides everything: the address never moves again.
      if (advance && address_reg == HALT_ADDR)
        state_next = S_HALTED;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (resolve && is_control && taken) begin
            target_next   = target;
            addr_err_next = (target[1:0] != 2'b00);
            state_next    = advance ? S_DELAY : S_TAKEN;
          end
          if (advance)
            address_next = seq_addr;
        end
        S_TAKEN: begin
          if (resolve && is_control)
            ds_err_next = 1'b1;
          if (advance) begin
            address_next = seq_addr;
            state_next   = S_DELAY;
          end
        end
        S_DELAY: begin
          if (resolve && is_control)
            ds_err_next = 1'b1;
          if (advance) begin
            address_next = target_reg;
            state_next   = S_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= S_RUN;
      address_reg  <= RESET_VECTOR;
      target_reg   <= '0;
      addr_err_reg <= 1'b0;
      ds_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      address_reg  <= address_next;
      target_reg   <= target_next;
      addr_err_reg <= addr_err_next;
      ds_err_reg   <= ds_err_next;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- directed vector table plus randomized run against a
// behavioural model of the program-counter unit.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        advance = 1'b0;
  logic        resolve = 1'b0;
  logic [6:0]  internal_code = 7'd0;
  logic [15:0] offset = 16'd0;
  logic [25:0] instr_index = 26'd0;
  logic [31:0] register_data = 32'd0;
  logic        zero = 1'b0, positive = 1'b0, negative = 1'b0;
  logic [31:0] address, link_address;
  logic        delay_slot, link_we, addr_err, ds_branch_err, halt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .advance(advance), .resolve(resolve),
    .internal_code(internal_code), .offset(offset), .instr_index(instr_index),
    .register_data(register_data), .zero(zero), .positive(positive),
    .negative(negative), .address(address), .delay_slot(delay_slot),
    .link_address(link_address), .link_we(link_we), .addr_err(addr_err),
    .ds_branch_err(ds_branch_err), .halt(halt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Directed vector: inputs for one cycle and the outputs expected during it.
  typedef struct {
    logic        adv, res;
    logic [6:0]  code;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] rdata;
    logic        z, p, n;
    logic [31:0] e_addr;
    logic        e_ds, e_lwe, e_aerr, e_dserr, e_halt;
  } vec_t;

  function automatic vec_t mk(logic adv, logic res, logic [6:0] code, logic [15:0] off,
                              logic [25:0] idx, logic [31:0] rdata, logic z,
                              logic [31:0] e_addr, logic e_ds, logic e_lwe,
                              logic e_aerr, logic e_dserr, logic e_halt);
    vec_t v;
    v.adv = adv; v.res = res; v.code = code; v.off = off; v.idx = idx;
    v.rdata = rdata; v.z = z; v.p = 1'b0; v.n = !z;
    v.e_addr = e_addr; v.e_ds = e_ds; v.e_lwe = e_lwe;
    v.e_aerr = e_aerr; v.e_dserr = e_dserr; v.e_halt = e_halt;
    return v;
  endfunction

  // Behavioural model: pc, number of advances left until a pending jump
  // lands (2 = branch still fetched, 1 = delay slot fetched), halted flag.
  logic [31:0] m_addr, m_tgt;
  int          m_cnt;
  bit          m_halted, m_aerr, m_dserr;

  function automatic bit m_halt_now();
    return m_halted || (m_addr == 32'h0);
  endfunction

  task automatic model_reset();
    m_addr = 32'hBFC00000; m_cnt = 0; m_halted = 0; m_aerr = 0; m_dserr = 0; m_tgt = 0;
  endtask

  task automatic model_step();
    bit          is_ctrl, tk;
    logic [31:0] tgt, nxt;
    bit          hal;
    hal = m_halt_now();
    m_aerr = 0; m_dserr = 0;
    if (hal) begin
      if (advance && m_addr == 32'h0) begin m_halted = 1; m_cnt = 0; end
      return;
    end
    is_ctrl = (internal_code >= 7'd30 && internal_code <= 7'd41);
    nxt = m_addr + 32'd4;
    tgt = nxt + ({{16{offset[15]}}, offset} * 32'd4);
    tk = 0;
    case (internal_code)
      7'd30: tk = zero;
      7'd37: tk = !zero;
      7'd33: tk = positive;
      7'd34: tk = zero || negative;
      7'd31, 7'd32: tk = positive || zero;
      7'd35, 7'd36: tk = negative;
      7'd38, 7'd39: begin tk = 1; tgt = {nxt[31:28], instr_index, 2'b00}; end
      7'd40, 7'd41: begin tk = 1; tgt = register_data; end
      default: tk = 0;
    endcase
    if (resolve && is_ctrl) begin
      if (m_cnt != 0) m_dserr = 1;
      else if (tk) begin m_tgt = tgt; m_cnt = 2; m_aerr = (tgt % 4) != 0; end
    end
    if (advance) begin
      if (m_cnt == 1) begin m_addr = m_tgt; m_cnt = 0; end
      else begin m_addr = nxt; if (m_cnt == 2) m_cnt = 1; end
    end
  endtask

  vec_t vecs[23];

  initial begin
    // Directed scenario from reset through branch, JAL, misaligned JR,
    // branch in delay slot, untaken BNE and halt at address 0.
    vecs[0]  = mk(1,0,0,   0,0,0,0, 32'hBFC00000,0,0,0,0,0);
    vecs[1]  = mk(1,0,0,   0,0,0,0, 32'hBFC00004,0,0,0,0,0);
    vecs[2]  = mk(1,0,0,   0,0,0,0, 32'hBFC00008,0,0,0,0,0);
    vecs[3]  = mk(1,0,0,   0,0,0,0, 32'hBFC0000C,0,0,0,0,0);
    vecs[4]  = mk(0,1,30,16'hFFFF,0,0,1, 32'hBFC00010,0,0,0,0,0);
    vecs[5]  = mk(1,0,0,   0,0,0,0, 32'hBFC00010,0,0,0,0,0);
    vecs[6]  = mk(1,0,0,   0,0,0,0, 32'hBFC00014,1,0,0,0,0);
    vecs[7]  = mk(1,0,0,   0,0,0,0, 32'hBFC00010,0,0,0,0,0);
    vecs[8]  = mk(1,0,0,   0,0,0,0, 32'hBFC00014,0,0,0,0,0);
    vecs[9]  = mk(1,0,0,   0,0,0,0, 32'hBFC00018,0,0,0,0,0);
    vecs[10] = mk(1,0,0,   0,0,0,0, 32'hBFC0001C,0,0,0,0,0);
    vecs[11] = mk(1,1,39,  0,26'h40,0,0, 32'hBFC00020,0,1,0,0,0);
    vecs[12] = mk(1,0,0,   0,0,0,0, 32'hBFC00024,1,0,0,0,0);
    vecs[13] = mk(0,1,41,  0,0,32'h402,0, 32'hB0000100,0,0,0,0,0);
    vecs[14] = mk(1,0,0,   0,0,0,0, 32'hB0000100,0,0,1,0,0);
    vecs[15] = mk(0,1,41,  0,0,32'h1000,0, 32'hB0000104,1,0,0,0,0);
    vecs[16] = mk(1,0,0,   0,0,0,0, 32'hB0000104,1,0,0,1,0);
    vecs[17] = mk(1,1,37,  0,0,0,1, 32'h00000402,0,0,0,0,0);
    vecs[18] = mk(1,1,41,  0,0,0,0, 32'h00000406,0,0,0,0,0);
    vecs[19] = mk(1,0,0,   0,0,0,0, 32'h0000040A,1,0,0,0,0);
    vecs[20] = mk(1,0,0,   0,0,0,0, 32'h00000000,0,0,0,0,1);
    vecs[21] = mk(1,0,0,   0,0,0,0, 32'h00000000,0,0,0,0,1);
    vecs[22] = mk(1,1,39,  0,0,0,0, 32'h00000000,0,0,0,0,1);

    #12 reset = 1'b0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      advance = vecs[i].adv; resolve = vecs[i].res; internal_code = vecs[i].code;
      offset = vecs[i].off; instr_index = vecs[i].idx; register_data = vecs[i].rdata;
      zero = vecs[i].z; positive = vecs[i].p; negative = vecs[i].n;
      #1;
      check($sformatf("v%0d address", i), address, vecs[i].e_addr);
      check($sformatf("v%0d link_address", i), link_address, vecs[i].e_addr + 32'd8);
      check($sformatf("v%0d delay_slot", i), {31'd0, delay_slot}, {31'd0, vecs[i].e_ds});
      check($sformatf("v%0d link_we", i), {31'd0, link_we}, {31'd0, vecs[i].e_lwe});
      check($sformatf("v%0d addr_err", i), {31'd0, addr_err}, {31'd0, vecs[i].e_aerr});
      check($sformatf("v%0d ds_branch_err", i), {31'd0, ds_branch_err}, {31'd0, vecs[i].e_dserr});
      check($sformatf("v%0d halt", i), {31'd0, halt}, {31'd0, vecs[i].e_halt});
      $display("vec %0d: addr=%h ds=%b lwe=%b aerr=%b dserr=%b halt=%b",
               i, address, delay_slot, link_we, addr_err, ds_branch_err, halt);
    end

    // Asynchronous reset away from any clock edge takes effect at once.
    @(negedge clk);
    advance = 1'b0; resolve = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async reset address", address, 32'hBFC00000);
    check("async reset halt", {31'd0, halt}, 32'd0);
    check("async reset delay_slot", {31'd0, delay_slot}, 32'd0);
    $display("async reset: addr=%h halt=%b", address, halt);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Randomized run against the model.
    for (int cyc = 0, hcnt = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (hcnt > 3 || (cyc % 97) == 96) begin
        reset = 1'b1;
        #1;
        check("rand reset address", address, 32'hBFC00000);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        hcnt = 0;
      end
      advance = ($urandom_range(0, 9) < 7);
      resolve = ($urandom_range(0, 9) < 3);
      internal_code = 7'($urandom_range(28, 43));
      offset = 16'($urandom_range(0, 31)) - 16'd16;
      instr_index = 26'($urandom);
      case ($urandom_range(0, 19))
        0:       register_data = 32'h0;
        1, 2:    register_data = 32'h2000 + 32'($urandom_range(0, 255));
        default: register_data = 32'h2000 + 32'($urandom_range(0, 255)) * 32'd4;
      endcase
      case ($urandom_range(0, 2))
        0: begin zero = 1; positive = 0; negative = 0; end
        1: begin zero = 0; positive = 1; negative = 0; end
        default: begin zero = 0; positive = 0; negative = 1; end
      endcase
      #1;
      check("rnd address", address, m_addr);
      check("rnd link_address", link_address, m_addr + 32'd8);
      check("rnd halt", {31'd0, halt}, {31'd0, m_halt_now()});
      check("rnd delay_slot", {31'd0, delay_slot}, {31'd0, (m_cnt == 1) && !m_halted});
      check("rnd link_we", {31'd0, link_we},
            {31'd0, resolve && !m_halt_now() && (internal_code == 7'd32 ||
             internal_code == 7'd36 || internal_code == 7'd39 || internal_code == 7'd40)});
      check("rnd addr_err", {31'd0, addr_err}, {31'd0, m_aerr});
      check("rnd ds_branch_err", {31'd0, ds_branch_err}, {31'd0, m_dserr});
      if (cyc % 100 == 0)
        $display("rnd %0d: addr=%h adv=%b res=%b code=%0d halt=%b", cyc, address,
                 advance, resolve, internal_code, halt);
      @(posedge clk);
      model_step();
      if (m_halt_now()) hcnt++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
